// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency SRAM port between instruction fetch and data accesses.
// Define ARB_RR_EN for round-robin arbitration; the default is data priority with inst anti-starvation.
module mem_port_arbiter #(
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  arb_grant
);

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  logic inst_win;
  logic grant_i;
  logic grant_d;

`ifdef ARB_RR_EN
  // High when the most recent grant went to the data side; a tie goes to the other side.
  logic last_data;

  always_comb inst_win = inst_req && (!data_req || last_data);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_data <= grant_d;
    end
  end
`else
  logic [3:0] starve_cnt;
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  always_comb inst_win = inst_req && (!data_req || starve_cnt == MaxWait);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || grant_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MaxWait) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Grants are gated by resetn so nothing reaches the RAM while reset is held.
  assign grant_i = resetn && inst_win;
  assign grant_d = resetn && data_req && !inst_win;

  assign inst_addr_ok = grant_i;
  assign data_addr_ok = grant_d;
  assign arb_grant    = {grant_d, grant_i};
  assign ram_en       = grant_i || grant_d;
  assign ram_we       = grant_d ? data_we : 4'h0;
  assign ram_wdata    = grant_d ? data_wdata : 32'h0;

  // NOTE: always_comb assigns a default first so no path leaves ram_addr holding a value (no latch).
  always_comb begin
    ram_addr = 32'h0;
    if (grant_d) begin
      ram_addr = data_addr;
    end else if (grant_i) begin
      ram_addr = inst_addr;
    end
  end

  logic [RAM_LAT-1:0] pipe_valid;
  owner_e             pipe_owner [RAM_LAT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= ram_en;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // NOTE: owner tags are qualified by pipe_valid, so they need no reset and stay a plain shift register.
  always_ff @(posedge clk) begin
    pipe_owner[0] <= grant_d ? OWN_DATA : OWN_INST;
    for (int i = 1; i < RAM_LAT; i++) begin
      pipe_owner[i] <= pipe_owner[i-1];
    end
  end

  assign inst_data_ok = pipe_valid[RAM_LAT-1] && (pipe_owner[RAM_LAT-1] == OWN_INST);
  assign data_data_ok = pipe_valid[RAM_LAT-1] && (pipe_owner[RAM_LAT-1] == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? ram_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RAM_LAT 1 and 3) share directed stimulus; per-instance monitors
// check every cycle's data_ok/rdata against queued expectations.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  logic        inst_addr_ok_v [2];
  logic        inst_data_ok_v [2];
  logic [31:0] inst_rdata_v   [2];
  logic        data_addr_ok_v [2];
  logic        data_data_ok_v [2];
  logic [31:0] data_rdata_v   [2];
  logic        ram_en_v       [2];
  logic [3:0]  ram_we_v       [2];
  logic [31:0] ram_addr_v     [2];
  logic [31:0] ram_wdata_v    [2];
  logic [31:0] ram_rdata_v    [2];
  logic [1:0]  arb_grant_v    [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        owner;
    logic        chk;
    logic [31:0] word;
    int          issue;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;

    mem_port_arbiter #(.RAM_LAT(L), .MAX_WAIT(MAX_WAIT)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok_v[g]),
      .inst_data_ok (inst_data_ok_v[g]),
      .inst_rdata   (inst_rdata_v[g]),
      .data_req     (data_req),
      .data_we      (data_we),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok_v[g]),
      .data_data_ok (data_data_ok_v[g]),
      .data_rdata   (data_rdata_v[g]),
      .ram_en       (ram_en_v[g]),
      .ram_we       (ram_we_v[g]),
      .ram_addr     (ram_addr_v[g]),
      .ram_wdata    (ram_wdata_v[g]),
      .ram_rdata    (ram_rdata_v[g]),
      .arb_grant    (arb_grant_v[g])
    );

    // Fixed-latency RAM model: word-addressed, byte writes land at the issuing edge.
    logic [31:0] mem  [256];
    logic [31:0] pipe [L];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h02800c0c;
      mem[1] = 32'h11111111;
      mem[2] = 32'h22222222;
    end

    always @(posedge clk) begin
      pipe[0] <= mem[ram_addr_v[g][9:2]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      if (ram_en_v[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we_v[g][b]) mem[ram_addr_v[g][9:2]][8*b +: 8] <= ram_wdata_v[g][8*b +: 8];
        end
      end
    end
    assign ram_rdata_v[g] = pipe[L-1];

    int idx = 0;
    always @(negedge clk) begin
      logic ei, ed, ck;
      logic [31:0] ew;
      ei = 1'b0; ed = 1'b0; ck = 1'b0; ew = 32'h0;
      if (!resetn) begin
        idx = sb.size();
      end else if (idx < sb.size() && sb[idx].issue + L == cyc) begin
        ei = !sb[idx].owner;
        ed = sb[idx].owner;
        ck = sb[idx].chk;
        ew = sb[idx].word;
        idx++;
      end
      check($sformatf("lat%0d_data_ok", L), {30'h0, data_data_ok_v[g], inst_data_ok_v[g]},
            {30'h0, ed, ei});
      if (!ei || ck) check($sformatf("lat%0d_inst_rdata", L), inst_rdata_v[g], ei ? ew : 32'h0);
      if (!ed || ck) check($sformatf("lat%0d_data_rdata", L), data_rdata_v[g], ed ? ew : 32'h0);
    end
  end

  // One cycle of stimulus; eg is the hand-computed grant {data, inst}, ew the word the granted read returns.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [3:0] dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] eg,
                      input logic [31:0] ew);
    @(posedge clk);
    #1;
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dw; data_addr = da; data_wdata = dwd;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("i%0d_arb_grant", g), {30'h0, arb_grant_v[g]}, {30'h0, eg});
      check($sformatf("i%0d_addr_ok", g), {30'h0, data_addr_ok_v[g], inst_addr_ok_v[g]},
            {30'h0, eg});
      check($sformatf("i%0d_ram_en", g), {31'h0, ram_en_v[g]}, {31'h0, |eg});
      check($sformatf("i%0d_ram_we", g), {28'h0, ram_we_v[g]}, {28'h0, eg[1] ? dw : 4'h0});
      check($sformatf("i%0d_ram_addr", g), ram_addr_v[g], eg[1] ? da : (eg[0] ? ia : 32'h0));
      if (eg[1]) check($sformatf("i%0d_ram_wdata", g), ram_wdata_v[g], dwd);
    end
    if (|eg) sb.push_back('{owner: eg[1], chk: eg[0] || dw == 4'h0, word: ew, issue: cyc});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0);
  endtask

  // Both sides request every cycle: inst reads 0x4 (0x11111111), data reads 0x8 (0x22222222).
  task automatic hold_both(input int n);
    logic [1:0] eg;
    for (int k = 0; k < n; k++) begin
`ifdef ARB_RR_EN
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      eg = (k % (MAX_WAIT + 1) == MAX_WAIT) ? 2'b01 : 2'b10;
`endif
      step(1'b1, 32'h4, 1'b1, 4'h0, 32'h8, 32'h0, eg, eg[1] ? 32'h22222222 : 32'h11111111);
    end
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; data_we = 4'hf;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("i%0d_rst_grant", g), {30'h0, arb_grant_v[g]}, 32'h0);
      check($sformatf("i%0d_rst_ram_en", g), {31'h0, ram_en_v[g]}, 32'h0);
      check($sformatf("i%0d_rst_ram_we", g), {28'h0, ram_we_v[g]}, 32'h0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    for (int k = 0; k < 3; k++) reset_cycle();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; data_we = 4'h0;

    // Lone fetch.
    step(1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h02800c0c);
    idle(4);

    // Contention: D x MAX_WAIT then I (or alternating when round-robin).
    hold_both(10);
    idle(4);

    // Store, read-back by fetch, partial store, read-back by both sides.
    step(1'b0, 32'h0, 1'b1, 4'hf, 32'h100, 32'hdeadbeef, 2'b10, 32'h0);
    step(1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hdeadbeef);
    step(1'b0, 32'h0, 1'b1, 4'h3, 32'h100, 32'h00001234, 2'b10, 32'h0);
    step(1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hdead1234);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 2'b10, 32'hdead1234);
    idle(4);

    // Back-to-back I, D, I: in-order responses at +L, +L+1, +L+2.
    step(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h02800c0c);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0, 2'b10, 32'h11111111);
    step(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h22222222);
    idle(4);

    // Reset pulse with accesses in flight: none may respond afterwards.
    step(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h02800c0c);
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0, 2'b10, 32'h11111111);
    reset_cycle();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    inst_req = 1'b0; data_req = 1'b0; data_we = 4'h0;
    @(negedge clk);
    idle(5);

    // Arbitration state restarts from reset values.
    hold_both(6);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
